result_display_scheduler: RTL and testbench

//  Sequences the shared unsigned->BCD converter for the coprocessor result path.

---
 rtl/result_display_scheduler_if.sv | 23 ++
 rtl/result_display_scheduler.sv | 120 ++++++++++++
 tb/tb_result_display_scheduler.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_display_scheduler_if.sv
// Result handshake and BCD converter bus shared by the display scheduler and its
// environment; the slave modport is the scheduler's view.
interface result_display_scheduler_if #(
    parameter int IN_W = 30
);
    logic            res_valid;
    logic [IN_W-1:0] res_data;
    logic            res_ready;
    logic            conv_trigger;
    logic [39:0]     conv_in;
    logic            conv_idle;
    logic [39:0]     conv_bcd;

    modport master (
        output res_valid, res_data, conv_idle, conv_bcd,
        input  res_ready, conv_trigger, conv_in
    );

    modport slave (
        input  res_valid, res_data, conv_idle, conv_bcd,
        output res_ready, conv_trigger, conv_in
    );
endinterface

// File: rtl/result_display_scheduler.sv
// Sequences one BCD conversion per accepted result, latches the BCD into a shadow
// register and scans it onto multiplexed seven-segment digits with zero blanking.
module result_display_scheduler #(
    parameter int IN_W        = 30,
    parameter int NDIGITS     = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    result_display_scheduler_if.slave  bus,
    output logic [NDIGITS-1:0]         an_n,
    output logic [3:0]                 digit_bcd,
    output logic                       digit_blank,
    output logic                       overflow
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] ARM    = 2'd2;
    localparam logic [1:0] WAIT   = 2'd3;

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);
    // Nibbles at or above NDIGITS; empty when all ten digits are physical.
    localparam logic [39:0] OVF_MASK = ~((40'd1 << (4 * NDIGITS)) - 40'd1);

    logic [1:0]         state;
    logic [39:0]        shadow;
    logic [IN_W-1:0]    res_word;
    logic [CNT_W-1:0]   refresh_cnt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_next;
    logic [NDIGITS-1:0] blank_vec;
    logic               upper_zero;

    assign res_word = bus.res_data;

    // ------------------------------------------------------------------
    // Conversion sequencer
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: shadow is reset like control state because the display must read
    // zero straight after reset, including an aborted conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            bus.res_ready    <= 1'b1;
            bus.conv_trigger <= 1'b0;
            bus.conv_in      <= '0;
            shadow           <= '0;
            overflow         <= 1'b0;
        end else begin
            bus.conv_trigger <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.res_valid) begin
                        bus.conv_in      <= 40'(res_word);
                        bus.conv_trigger <= 1'b1;
                        bus.res_ready    <= 1'b0;
                        state            <= LAUNCH;
                    end
                end
                LAUNCH: state <= ARM;
                // conv_idle may still be high from before the trigger landed.
                ARM:    state <= WAIT;
                WAIT: begin
                    if (bus.conv_idle) begin
                        shadow        <= bus.conv_bcd;
                        overflow      <= |(bus.conv_bcd & OVF_MASK);
                        bus.res_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero blanking: digit i blanks when it and all digits above
    // it are zero; digit 0 always shows.
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        upper_zero = 1'b1;
        blank_vec  = '0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            upper_zero   = upper_zero && (shadow[4*i +: 4] == 4'd0);
            blank_vec[i] = upper_zero && (i != 0);
        end
    end

    assign idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    // ------------------------------------------------------------------
    // Digit scan, independent of the sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            idx         <= '0;
            an_n        <= ~NDIGITS'(1);
            digit_bcd   <= 4'd0;
            digit_blank <= 1'b0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            idx         <= idx_next;
            an_n        <= ~(NDIGITS'(1) << idx_next);
            digit_bcd   <= 4'(shadow >> (4 * idx_next));
            digit_blank <= blank_vec[idx_next] & ~overflow;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_result_display_scheduler.sv
// Directed bench for result_display_scheduler with a behavioural BCD converter model.
module tb_result_display_scheduler;

    localparam int IN_W        = 30;
    localparam int NDIGITS     = 8;
    localparam int REFRESH_DIV = 4;
    localparam int CONV_LAT    = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] an_n;
    logic [3:0] digit_bcd;
    logic       digit_blank;
    logic       overflow;

    int tests_run    = 0;
    int tests_failed = 0;
    int trig_count   = 0;

    logic [3:0] seen_bcd   [8];
    logic       seen_blank [8];
    logic [7:0] seen_hit;

    always #5 clk = ~clk;

    result_display_scheduler_if #(.IN_W(IN_W)) bus ();

    result_display_scheduler #(
        .IN_W(IN_W), .NDIGITS(NDIGITS), .REFRESH_DIV(REFRESH_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .an_n(an_n), .digit_bcd(digit_bcd), .digit_blank(digit_blank),
        .overflow(overflow)
    );

    // Converter model: idle drops after a trigger, BCD appears when idle rises.
    logic        model_idle = 1'b1;
    logic [39:0] model_bcd  = '0;
    logic [39:0] model_val  = '0;
    int          model_lat  = 0;

    assign bus.conv_idle = model_idle;
    assign bus.conv_bcd  = model_bcd;

    function automatic logic [39:0] to_bcd(input logic [39:0] v);
        logic [39:0] r;
        logic [39:0] t;
        r = '0;
        t = v;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(t % 40'd10);
            t = t / 40'd10;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.conv_trigger) begin
            trig_count = trig_count + 1;
            model_idle <= 1'b0;
            model_lat  <= CONV_LAT - 1;
            model_val  <= to_bcd(bus.conv_in);
        end else if (model_lat != 0) begin
            model_lat <= model_lat - 1;
            if (model_lat == 1) begin
                model_idle <= 1'b1;
                model_bcd  <= model_val;
            end
        end
    end

    // Present a result and return at the negedge of the LAUNCH cycle.
    task automatic send_result(input logic [IN_W-1:0] v, output bit ok);
        @(negedge clk);
        bus.res_valid = 1'b1;
        bus.res_data  = v;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.res_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.res_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.res_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Let the scan settle a full rotation, then record what each digit shows.
    task automatic collect_digits;
        seen_hit = '0;
        for (int j = 0; j < 8; j++) begin
            seen_bcd[j]   = 4'hx;
            seen_blank[j] = 1'bx;
        end
        repeat (36) @(negedge clk);
        repeat (36) begin
            @(negedge clk);
            for (int j = 0; j < 8; j++) begin
                if (an_n == ~(8'd1 << j)) begin
                    seen_bcd[j]   = digit_bcd;
                    seen_blank[j] = digit_blank;
                    seen_hit[j]   = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset;
        logic [31:0] ew;
        logic [7:0]  eb;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (13) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        tests_run++;
        if (an_n !== 8'hFE || digit_bcd !== 4'd0 || digit_blank !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_display: an_n=%h bcd=%0d blank=%0b, expected FE 0 0",
                     an_n, digit_bcd, digit_blank);
        end
        tests_run++;
        if (bus.res_ready !== 1'b1 || bus.conv_trigger !== 1'b0 ||
            bus.conv_in !== 40'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: ready=%0b trig=%0b conv_in=%h ovf=%0b, expected 1 0 0 0",
                     bus.res_ready, bus.conv_trigger, bus.conv_in, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        collect_digits();
        ew = 32'h0;
        eb = 8'hFE;
        tests_run++;
        if (seen_hit !== 8'hFF) begin
            tests_failed++;
            $display("FAIL reset_scan_hit: digits seen %b, expected 11111111", seen_hit);
        end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (seen_bcd[i] !== ew[4*i +: 4] || seen_blank[i] !== eb[i]) begin
                tests_failed++;
                $display("FAIL reset_digit%0d: bcd=%0d blank=%0b, expected bcd=%0d blank=%0b",
                         i, seen_bcd[i], seen_blank[i], ew[4*i +: 4], eb[i]);
            end
        end
    endtask

    task automatic test_scan;
        logic [7:0] prev;
        logic [7:0] exp_an;
        bit         seen_step;
        int         start;
        seen_step = 1'b0;
        start = 0;
        @(negedge clk);
        prev = an_n;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an_n !== prev) begin
                seen_step = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!seen_step) begin
            tests_failed++;
            $display("FAIL scan_step_timeout: an_n stuck at %h", an_n);
        end
        for (int j = 0; j < 8; j++)
            if (an_n == ~(8'd1 << j)) start = j;
        for (int k = 0; k <= 32; k++) begin
            exp_an = ~(8'd1 << ((start + k) % 8));
            tests_run++;
            if (an_n !== exp_an) begin
                tests_failed++;
                $display("FAIL scan_first_k%0d: an_n=%h, expected %h", k, an_n, exp_an);
            end
            repeat (3) @(negedge clk);
            tests_run++;
            if (an_n !== exp_an) begin
                tests_failed++;
                $display("FAIL scan_last_k%0d: an_n=%h, expected %h", k, an_n, exp_an);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_convert_12345;
        bit          ok;
        int          trig0;
        logic [31:0] ew;
        logic [7:0]  eb;
        trig0 = trig_count;
        send_result(30'd12345, ok);
        tests_run++;
        if (!ok || bus.conv_trigger !== 1'b1 || bus.conv_in !== 40'd12345) begin
            tests_failed++;
            $display("FAIL conv1_launch: accepted=%0b trig=%0b conv_in=%0d, expected 1 1 12345",
                     ok, bus.conv_trigger, bus.conv_in);
        end
        @(negedge clk);
        tests_run++;
        if (bus.conv_trigger !== 1'b0 || bus.res_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL conv1_pulse: trig=%0b ready=%0b in ARM, expected 0 0",
                     bus.conv_trigger, bus.res_ready);
        end
        wait_done(ok);
        tests_run++;
        if (!ok || trig_count - trig0 != 1) begin
            tests_failed++;
            $display("FAIL conv1_done: done=%0b triggers=%0d, expected 1 1", ok, trig_count - trig0);
        end
        collect_digits();
        ew = 32'h00012345;
        eb = 8'hE0;
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL conv1_overflow: got %0b, expected 0", overflow);
        end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (seen_bcd[i] !== ew[4*i +: 4] || seen_blank[i] !== eb[i]) begin
                tests_failed++;
                $display("FAIL conv1_digit%0d: bcd=%0d blank=%0b, expected bcd=%0d blank=%0b",
                         i, seen_bcd[i], seen_blank[i], ew[4*i +: 4], eb[i]);
            end
        end
    endtask

    task automatic test_overflow;
        bit          ok;
        logic [31:0] ew;
        send_result(30'h3FFFFFFF, ok);
        // Previous value stays on the display while converting.
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_during_conv: overflow=%0b, expected 0", overflow);
        end
        wait_done(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL ovf_done: conversion did not complete in 200 cycles");
        end
        collect_digits();
        ew = 32'h73741823;
        tests_run++;
        if (overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_flag: got %0b, expected 1", overflow);
        end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (seen_bcd[i] !== ew[4*i +: 4] || seen_blank[i] !== 1'b0) begin
                tests_failed++;
                $display("FAIL ovf_digit%0d: bcd=%0d blank=%0b, expected bcd=%0d blank=0",
                         i, seen_bcd[i], seen_blank[i], ew[4*i +: 4]);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit          ok;
        bit          idle_seen;
        int          trig0;
        logic [31:0] ew;
        logic [7:0]  eb;
        trig0 = trig_count;
        send_result(30'd999, ok);
        bus.res_valid = 1'b1;
        bus.res_data  = 30'd7;
        tests_run++;
        if (bus.res_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_launch_ready: got %0b, expected 0", bus.res_ready);
        end
        @(negedge clk);
        idle_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.res_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_held_off: ready=%0b at wait cycle %0d, expected 0",
                         bus.res_ready, i);
            end
            if (bus.conv_idle) begin
                idle_seen = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!idle_seen) begin
            tests_failed++;
            $display("FAIL b2b_idle_timeout: conv_idle never rose");
        end
        @(negedge clk);
        tests_run++;
        if (bus.res_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready_rise: ready=%0b after shadow update, expected 1",
                     bus.res_ready);
        end
        @(negedge clk);
        bus.res_valid = 1'b0;
        tests_run++;
        if (bus.conv_trigger !== 1'b1 || bus.conv_in !== 40'd7) begin
            tests_failed++;
            $display("FAIL b2b_second_launch: trig=%0b conv_in=%0d, expected 1 7",
                     bus.conv_trigger, bus.conv_in);
        end
        wait_done(ok);
        repeat (20) @(negedge clk);
        tests_run++;
        if (!ok || trig_count - trig0 != 2) begin
            tests_failed++;
            $display("FAIL b2b_triggers: done=%0b triggers=%0d, expected 1 2", ok, trig_count - trig0);
        end
        collect_digits();
        ew = 32'h7;
        eb = 8'hFE;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (seen_bcd[i] !== ew[4*i +: 4] || seen_blank[i] !== eb[i]) begin
                tests_failed++;
                $display("FAIL b2b_digit%0d: bcd=%0d blank=%0b, expected bcd=%0d blank=%0b",
                         i, seen_bcd[i], seen_blank[i], ew[4*i +: 4], eb[i]);
            end
        end
    endtask

    task automatic test_reset_in_wait;
        bit          ok;
        int          trig0;
        logic [31:0] ew;
        logic [7:0]  eb;
        send_result(30'd5555, ok);
        repeat (4) @(negedge clk);
        trig0 = trig_count;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        tests_run++;
        if (trig_count != trig0 || bus.res_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_state: extra triggers=%0d ready=%0b, expected 0 1",
                     trig_count - trig0, bus.res_ready);
        end
        collect_digits();
        ew = 32'h0;
        eb = 8'hFE;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (seen_bcd[i] !== ew[4*i +: 4] || seen_blank[i] !== eb[i]) begin
                tests_failed++;
                $display("FAIL abort_digit%0d: bcd=%0d blank=%0b, expected bcd=%0d blank=%0b",
                         i, seen_bcd[i], seen_blank[i], ew[4*i +: 4], eb[i]);
            end
        end
        send_result(30'd42, ok);
        wait_done(ok);
        tests_run++;
        if (!ok || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_abort_done: done=%0b ovf=%0b, expected 1 0", ok, overflow);
        end
        collect_digits();
        ew = 32'h42;
        eb = 8'hFC;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (seen_bcd[i] !== ew[4*i +: 4] || seen_blank[i] !== eb[i]) begin
                tests_failed++;
                $display("FAIL after_abort_digit%0d: bcd=%0d blank=%0b, expected bcd=%0d blank=%0b",
                         i, seen_bcd[i], seen_blank[i], ew[4*i +: 4], eb[i]);
            end
        end
    endtask

    initial begin
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        test_reset();
        test_scan();
        test_convert_12345();
        test_overflow();
        test_back_to_back();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
